// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared grid width, FSM state and halt-cause types for the life sequencer
package life_pkg;

   localparam int GRID_W = 64;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      HALT  = 3'd4
   } life_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_EXTINCT = 2'b01,
      CAUSE_STILL   = 2'b10,
      CAUSE_OSC2    = 2'b11
   } halt_cause_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/life_sequencer_if.sv
// rtl/life_sequencer_if.sv - control pulses, grid views and sequencer outputs
interface life_sequencer_if #(parameter int GRID_W = life_pkg::GRID_W);

   logic              start;
   logic              randomize_req;
   logic              pause;
   logic              step;
   logic [GRID_W-1:0] grid_cur;
   logic [GRID_W-1:0] grid_next;
   logic              load_en;
   logic              load_sel;
   logic              evolve_en;
   logic [15:0]       gen_count;
   logic [2:0]        state;
   logic [1:0]        halt_cause;

   modport master (
      output start, randomize_req, pause, step, grid_cur, grid_next,
      input  load_en, load_sel, evolve_en, gen_count, state, halt_cause
   );

   modport slave (
      input  start, randomize_req, pause, step, grid_cur, grid_next,
      output load_en, load_sel, evolve_en, gen_count, state, halt_cause
   );

endinterface

// File: rtl/life_tick.sv
// rtl/life_tick.sv - generation prescaler; tick marks the last cycle of each TICK_DIV period
module life_tick #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int          W    = $clog2(TICK_DIV);
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
      end
   end

   assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - Game-of-Life run/pause/step sequencer with extinction and oscillation halt detection
module life_sequencer #(
   parameter int GRID_W   = life_pkg::GRID_W,
   parameter int TICK_DIV = 25_000_000
) (
   input  logic              clk,
   input  logic              reset,
   life_sequencer_if.slave   bus
);

   import life_pkg::*;

   life_state_t       st;
   halt_cause_t       cause;
   halt_cause_t       hit;
   logic              ret_run;
   logic [GRID_W-1:0] prev;
   logic              prev_valid;
   logic              load_en;
   logic              load_sel;
   logic              evolve_en;
   logic [15:0]       gen_count;
   logic              tick;
   logic              tick_clear;
   logic              load_req;
   logic              halting;

   // Counter only runs in RUN; leaving RUN or a pause restarts the period.
   assign tick_clear = (st != RUN) || bus.pause;

   life_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .enable (st == RUN),
      .clear  (tick_clear),
      .tick   (tick)
   );

   always_comb begin
      hit = CAUSE_NONE;
      if (bus.grid_next == '0) begin
         hit = CAUSE_EXTINCT;
      end else if (bus.grid_next == bus.grid_cur) begin
         hit = CAUSE_STILL;
      end else if (prev_valid && (bus.grid_next == prev)) begin
         hit = CAUSE_OSC2;
      end
   end

   // Randomize outranks start; RUN and LOAD never reload.
   assign load_req = ((st == IDLE) || (st == HALT)) ? (bus.randomize_req || bus.start)
                   : (st == PAUSE)                  ? bus.randomize_req
                   :                                  1'b0;

   assign halting = evolve_en && (hit != CAUSE_NONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= IDLE;
         cause      <= CAUSE_NONE;
         ret_run    <= 1'b0;
         prev       <= '0;
         prev_valid <= 1'b0;
         load_en    <= 1'b0;
         load_sel   <= 1'b0;
         evolve_en  <= 1'b0;
         gen_count  <= '0;
      end else begin
         load_en   <= 1'b0;
         evolve_en <= 1'b0;
         if (evolve_en) begin
            gen_count  <= sat_inc(gen_count);
            prev       <= bus.grid_cur;
            prev_valid <= 1'b1;
         end
         if (load_req) begin
            st         <= LOAD;
            load_en    <= 1'b1;
            load_sel   <= bus.randomize_req;
            ret_run    <= !bus.randomize_req;
            gen_count  <= '0;
            cause      <= CAUSE_NONE;
            prev_valid <= 1'b0;
         end else if (halting) begin
            st    <= HALT;
            cause <= hit;
         end else begin
            case (st)
               LOAD:  st <= ret_run ? RUN : PAUSE;
               RUN: begin
                  if (bus.pause) begin
                     st <= PAUSE;
                  end else if (tick) begin
                     evolve_en <= 1'b1;
                  end
               end
               PAUSE: begin
                  if (bus.start) begin
                     st <= RUN;
                  end else if (bus.step && !evolve_en) begin
                     evolve_en <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.load_en    = load_en;
   assign bus.load_sel   = load_sel;
   assign bus.evolve_en  = evolve_en;
   assign bus.gen_count  = gen_count;
   assign bus.state      = st;
   assign bus.halt_cause = cause;

endmodule

// File: doc/life_sequencer.md
LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 Parameter GRID_W, default 64: width of the cell-grid vector.
REQ-002 Parameter TICK_DIV, default 25_000_000: clock cycles per generation in RUN; legal range 2 and up.
REQ-003 Port clk, input, 1: single system clock, rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse; load the fixed seed and run, or resume from PAUSE.
REQ-006 Port randomize, input, 1: one-cycle pulse; load the LFSR grid and enter PAUSE.
REQ-007 Port pause, input, 1: one-cycle pulse; stop free-running.
REQ-008 Port step, input, 1: one-cycle pulse; single generation while paused.
REQ-009 Port grid_cur, input, GRID_W: the current registered grid.
REQ-010 Port grid_next, input, GRID_W: the next generation from the datapath.
REQ-011 Port load_en, output, 1: grid register loads the selected source.
REQ-012 Port load_sel, output, 1: grid source select; 0 = fixed seed, 1 = LFSR.
REQ-013 Port evolve_en, output, 1: grid register captures grid_next.
REQ-014 Port gen_count, output, 16: number of generations since the last load.
REQ-015 Port state, output, 3: encoded FSM state.
REQ-016 Port halt_cause, output, 2: 00 none, 01 extinct, 10 still life, 11 period-2 oscillator.

Function
REQ-017 The block SHALL implement the states IDLE, LOAD, RUN, PAUSE and HALT.
REQ-018 When more than one control input is high in a cycle, priority SHALL be reset > randomize > start > pause > step.
REQ-019 In IDLE or HALT, start SHALL go to LOAD with load_sel=0 and a return target of RUN.
REQ-020 In IDLE, PAUSE or HALT, randomize SHALL go to LOAD with load_sel=1 and a return target of PAUSE.
REQ-021 In RUN, randomize SHALL be ignored.
REQ-022 LOAD SHALL last exactly one cycle with load_en=1, then move to its return target.
REQ-023 LOAD SHALL clear gen_count, halt_cause, the tick counter and the prev-valid flag.
REQ-024 load_sel SHALL hold its last value outside LOAD.
REQ-025 In RUN, the tick counter SHALL count 0..TICK_DIV-1 and wrap.
REQ-026 evolve_en SHALL be high exactly in RUN cycles where the tick counter equals TICK_DIV-1; the first evolve occurs TICK_DIV cycles after entering RUN.
REQ-027 In RUN, pause SHALL go to PAUSE, suppress any evolve_en in that cycle and clear the tick counter.
REQ-028 In PAUSE, a step pulse SHALL give one evolve_en in the following cycle; a step arriving while that evolve is pending SHALL be ignored.
REQ-029 In PAUSE, start SHALL resume RUN without a load, with the tick counter cleared.
REQ-030 In every evolve_en cycle, gen_count SHALL increment, saturating at 0xFFFF.
REQ-031 In every evolve_en cycle, grid_cur SHALL be stored into prev and prev-valid SHALL be set.
REQ-032 Halt check, performed in each evolve_en cycle, first match wins: grid_next all zero -> 01; grid_next==grid_cur -> 10; prev-valid and grid_next==prev -> 11.
REQ-033 On a halt match, that evolve SHALL still be applied, and the next cycle SHALL be HALT with halt_cause latched.
REQ-034 HALT SHALL issue no evolve_en; HALT is left only via start or randomize (REQ-019, REQ-020).
REQ-035 Every output SHALL be a function of registered state only; no combinational input-to-output path.

Reset
REQ-036 Reset SHALL put the block in IDLE.
REQ-037 Reset SHALL drive load_en=0, load_sel=0, evolve_en=0, gen_count=0 and halt_cause=00.
REQ-038 Reset SHALL clear the tick counter, prev and prev-valid.
REQ-039 Reset asserted mid-RUN or mid-LOAD SHALL take effect at the next edge and suppress any pending evolve or load.

Structure
REQ-040 A shared package life_pkg SHALL hold GRID_W, the state enum and the halt-cause enum.
REQ-041 The prescaler SHALL be a sub-module life_tick (enable, clear, tick output), parameterized by TICK_DIV.

Verification (TICK_DIV=4, behavioral grid model)
REQ-042 Bench: reset, then start -> load_en high 1 cycle with load_sel=0; evolve_en on cycles 4, 8 and 12 after RUN entry; gen_count=3 at cycle 13.
REQ-043 Bench: RUN, pause in the same cycle as a tick -> no evolve_en; state PAUSE; gen_count unchanged.
REQ-044 Bench: PAUSE, three step pulses 5 cycles apart -> exactly three evolve_en pulses, each one cycle after its step.
REQ-045 Bench: seed a 2x2 block -> after the first evolve, HALT with halt_cause=10 and gen_count=1.
REQ-046 Bench: seed a blinker -> HALT with halt_cause=11 after evolve 2; a single-cell seed -> HALT with halt_cause=01 after evolve 1.
REQ-047 Bench: randomize and start high in the same cycle from IDLE -> LOAD with load_sel=1, then PAUSE; reset mid-RUN -> IDLE with all outputs at reset values.
